// File: rtl/iob_soc_opencryptolinux_sram_arbiter_pkg.sv
// Shared constants for the main-SRAM arbiter: port identifiers and priority modes.
package iob_soc_opencryptolinux_sram_arbiter_pkg;

    localparam logic ARB_PORT_I = 1'b0;
    localparam logic ARB_PORT_D = 1'b1;

    localparam int unsigned PRIO_ROUND_ROBIN = 0;
    localparam int unsigned PRIO_FIXED       = 1;

endpackage

// File: rtl/iob_soc_opencryptolinux_sram_arbiter_if.sv
// One IOb-native memory port: request, accept and read-return signals.
interface iob_soc_opencryptolinux_sram_arbiter_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  ready;
    logic [DATA_W-1:0]     rdata;
    logic                  rvalid;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata, rvalid);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata, rvalid);
endinterface

// File: rtl/iob_reg_r.sv
// Plain register with synchronous active-high reset to a fixed value.
module iob_reg_r #(
    parameter int unsigned        DATA_W  = 1,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) data_q <= RST_VAL;
        else       data_q <= data_i;
    end

    assign data_o = data_q;
endmodule

// File: rtl/iob_soc_opencryptolinux_sram_arbiter.sv
// Shares one single-port byte-enable SRAM between the CPU instruction and data buses,
// one access per cycle, routing each one-cycle-latency read back to its requester.
module iob_soc_opencryptolinux_sram_arbiter
    import iob_soc_opencryptolinux_sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIXED_PRIO = PRIO_ROUND_ROBIN
) (
    input  logic                clk_i,
    input  logic                rst_i,
    iob_soc_opencryptolinux_sram_arbiter_if.slave i_bus_io,
    iob_soc_opencryptolinux_sram_arbiter_if.slave d_bus_io,
    output logic                spram_en_o,
    output logic [ADDR_W-1:0]   spram_addr_o,
    output logic [DATA_W/8-1:0] spram_we_o,
    output logic [DATA_W-1:0]   spram_di_o,
    input  logic [DATA_W-1:0]   spram_do_i
);
    logic i_req, d_req, gnt_i, gnt_d, rd_go;
    logic prio_q, prio_d, rd_pend_q, rd_pend_d, rd_own_q, rd_own_d;

    // Requests are masked during reset so nothing is accepted or advanced.
    assign i_req = i_bus_io.valid & ~rst_i;
    assign d_req = d_bus_io.valid & ~rst_i;

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (i_req && d_req) begin
            if (FIXED_PRIO == PRIO_FIXED || prio_q == ARB_PORT_D) gnt_d = 1'b1;
            else                                                  gnt_i = 1'b1;
        end else begin
            gnt_i = i_req;
            gnt_d = d_req;
        end
    end

    always_comb begin
        spram_en_o   = 1'b0;
        spram_addr_o = '0;
        spram_we_o   = '0;
        spram_di_o   = '0;
        if (gnt_i) begin
            spram_en_o   = 1'b1;
            spram_addr_o = i_bus_io.addr;
            spram_we_o   = i_bus_io.wstrb;
            spram_di_o   = i_bus_io.wdata;
        end else if (gnt_d) begin
            spram_en_o   = 1'b1;
            spram_addr_o = d_bus_io.addr;
            spram_we_o   = d_bus_io.wstrb;
            spram_di_o   = d_bus_io.wdata;
        end
    end

    assign rd_go = spram_en_o & ~(|spram_we_o);

    always_comb begin
        prio_d = prio_q;
        if (gnt_i)      prio_d = ARB_PORT_D;
        else if (gnt_d) prio_d = ARB_PORT_I;
        rd_pend_d = rd_go;
        rd_own_d  = rd_go ? (gnt_d ? ARB_PORT_D : ARB_PORT_I) : rd_own_q;
    end

    iob_reg_r #(
        .DATA_W  (3),
        .RST_VAL (3'b000)
    ) u_state_reg (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data_i ({prio_d, rd_pend_d, rd_own_d}),
        .data_o ({prio_q, rd_pend_q, rd_own_q})
    );

    assign i_bus_io.ready  = gnt_i;
    assign d_bus_io.ready  = gnt_d;
    assign i_bus_io.rdata  = spram_do_i;
    assign d_bus_io.rdata  = spram_do_i;
    // A read pending across a newly asserted reset is dropped.
    assign i_bus_io.rvalid = rd_pend_q & (rd_own_q == ARB_PORT_I) & ~rst_i;
    assign d_bus_io.rvalid = rd_pend_q & (rd_own_q == ARB_PORT_D) & ~rst_i;
endmodule

// File: tb/tb_iob_soc_opencryptolinux_sram_arbiter.sv
// Directed bench: round-robin arbiter against a behavioural byte-enable RAM,
// plus a fixed-priority instance for the starvation case.
module tb_iob_soc_opencryptolinux_sram_arbiter;
    localparam int unsigned AW = 13;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iob_soc_opencryptolinux_sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) i_bus ();
    iob_soc_opencryptolinux_sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) d_bus ();
    iob_soc_opencryptolinux_sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fi_bus ();
    iob_soc_opencryptolinux_sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fd_bus ();

    logic          en, f_en;
    logic [AW-1:0] addr, f_addr;
    logic [3:0]    we, f_we;
    logic [DW-1:0] di, f_di;
    logic [DW-1:0] ram_do;
    logic [DW-1:0] f_do;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    iob_soc_opencryptolinux_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
        .clk_i(clk), .rst_i(rst), .i_bus_io(i_bus), .d_bus_io(d_bus),
        .spram_en_o(en), .spram_addr_o(addr), .spram_we_o(we), .spram_di_o(di),
        .spram_do_i(ram_do)
    );

    iob_soc_opencryptolinux_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fix (
        .clk_i(clk), .rst_i(rst), .i_bus_io(fi_bus), .d_bus_io(fd_bus),
        .spram_en_o(f_en), .spram_addr_o(f_addr), .spram_we_o(f_we), .spram_di_o(f_di),
        .spram_do_i(f_do)
    );

    // Registered-output RAM; preloaded on reset.
    always @(posedge clk) begin
        if (rst) begin
            mem[13'h010] <= 32'hDEADBEEF;
            mem[13'h001] <= 32'h11111111;
            mem[13'h100] <= 32'h22222222;
            mem[13'h030] <= 32'hAAAAAAAA;
        end else if (en) begin
            for (int b = 0; b < 4; b++)
                if (we[b]) mem[addr][8*b +: 8] <= di[8*b +: 8];
            ram_do <= mem[addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        i_bus.valid = 0; i_bus.addr = '0; i_bus.wdata = '0; i_bus.wstrb = '0;
        d_bus.valid = 0; d_bus.addr = '0; d_bus.wdata = '0; d_bus.wstrb = '0;
        fi_bus.valid = 0; fi_bus.addr = '0; fi_bus.wdata = '0; fi_bus.wstrb = '0;
        fd_bus.valid = 0; fd_bus.addr = '0; fd_bus.wdata = '0; fd_bus.wstrb = '0;
    endtask

    initial begin
        logic exp_i, prev_i;
        f_do = '0;
        rst  = 1'b1;
        idle_all();
        next_cycle();
        next_cycle();

        // Requests are ignored while reset is held.
        i_bus.valid = 1; i_bus.addr = 13'h010;
        #1;
        check("rst_i_ready", {31'd0, i_bus.ready}, 32'd0);
        check("rst_en", {31'd0, en}, 32'd0);
        check("rst_rvalid", {30'd0, i_bus.rvalid, d_bus.rvalid}, 32'd0);
        next_cycle();
        rst = 0;

        // Lone I read.
        #1;
        check("t1_i_ready", {31'd0, i_bus.ready}, 32'd1);
        check("t1_d_ready", {31'd0, d_bus.ready}, 32'd0);
        check("t1_addr", {19'd0, addr}, 32'h010);
        next_cycle();
        i_bus.valid = 0;
        #1;
        check("t1_i_rvalid", {31'd0, i_bus.rvalid}, 32'd1);
        check("t1_i_rdata", i_bus.rdata, 32'hDEADBEEF);
        check("t1_d_rvalid", {31'd0, d_bus.rvalid}, 32'd0);
        check("idle_en", {31'd0, en}, 32'd0);

        // Lone D read; leaves priority pointing at I.
        d_bus.valid = 1; d_bus.addr = 13'h100;
        #1;
        check("d1_d_ready", {31'd0, d_bus.ready}, 32'd1);
        next_cycle();
        d_bus.valid = 0;
        #1;
        check("d1_d_rvalid", {31'd0, d_bus.rvalid}, 32'd1);
        check("d1_d_rdata", d_bus.rdata, 32'h22222222);

        // Continuous contention: strict I/D alternation, returns one cycle later.
        prev_i = 0;
        for (int k = 0; k < 6; k++) begin
            i_bus.valid = 1; i_bus.addr = 13'h001;
            d_bus.valid = 1; d_bus.addr = 13'h100;
            exp_i = (k % 2 == 0);
            #1;
            check($sformatf("rr%0d_i_ready", k), {31'd0, i_bus.ready}, {31'd0, exp_i});
            check($sformatf("rr%0d_d_ready", k), {31'd0, d_bus.ready}, {31'd0, ~exp_i});
            check($sformatf("rr%0d_addr", k), {19'd0, addr}, exp_i ? 32'h001 : 32'h100);
            if (k > 0) begin
                check($sformatf("rr%0d_i_rvalid", k), {31'd0, i_bus.rvalid}, {31'd0, prev_i});
                check($sformatf("rr%0d_d_rvalid", k), {31'd0, d_bus.rvalid}, {31'd0, ~prev_i});
                check($sformatf("rr%0d_rdata", k), i_bus.rdata,
                      prev_i ? 32'h11111111 : 32'h22222222);
            end
            prev_i = exp_i;
            next_cycle();
        end
        idle_all();
        #1;
        check("rr_last_d_rvalid", {31'd0, d_bus.rvalid}, 32'd1);
        check("rr_last_rdata", d_bus.rdata, 32'h22222222);

        // D full write, then I reads it back.
        d_bus.valid = 1; d_bus.addr = 13'h020; d_bus.wdata = 32'hCAFEF00D; d_bus.wstrb = 4'hF;
        #1;
        check("wr_d_ready", {31'd0, d_bus.ready}, 32'd1);
        check("wr_we", {28'd0, we}, 32'hF);
        check("wr_di", di, 32'hCAFEF00D);
        next_cycle();
        idle_all();
        i_bus.valid = 1; i_bus.addr = 13'h020;
        #1;
        check("wr_no_d_rvalid", {31'd0, d_bus.rvalid}, 32'd0);
        check("rb_i_ready", {31'd0, i_bus.ready}, 32'd1);
        next_cycle();
        idle_all();
        #1;
        check("rb_i_rvalid", {31'd0, i_bus.rvalid}, 32'd1);
        check("rb_i_rdata", i_bus.rdata, 32'hCAFEF00D);

        // Partial write merges into the existing word.
        d_bus.valid = 1; d_bus.addr = 13'h030; d_bus.wdata = 32'h00001234; d_bus.wstrb = 4'h3;
        next_cycle();
        d_bus.wdata = '0; d_bus.wstrb = '0;
        next_cycle();
        idle_all();
        #1;
        check("pw_d_rvalid", {31'd0, d_bus.rvalid}, 32'd1);
        check("pw_rdata", d_bus.rdata, 32'hAAAA1234);

        // Reset during a pending read drops it and returns priority to I.
        i_bus.valid = 1; i_bus.addr = 13'h010;
        #1;
        check("rr_i_ready", {31'd0, i_bus.ready}, 32'd1);
        next_cycle();
        idle_all();
        rst = 1;
        #1;
        check("rr_rvalid_dropped", {31'd0, i_bus.rvalid}, 32'd0);
        check("rr_ready_in_rst", {31'd0, d_bus.ready}, 32'd0);
        next_cycle();
        rst = 0;
        i_bus.valid = 1; i_bus.addr = 13'h001;
        d_bus.valid = 1; d_bus.addr = 13'h100;
        #1;
        check("post_rst_i_ready", {31'd0, i_bus.ready}, 32'd1);
        check("post_rst_d_ready", {31'd0, d_bus.ready}, 32'd0);
        next_cycle();
        idle_all();

        // Fixed priority: D always wins; I only gets in when D drops.
        for (int k = 0; k < 4; k++) begin
            fi_bus.valid = 1; fi_bus.addr = 13'h005;
            fd_bus.valid = 1; fd_bus.addr = 13'h006;
            #1;
            check($sformatf("fp%0d_d_ready", k), {31'd0, fd_bus.ready}, 32'd1);
            check($sformatf("fp%0d_i_ready", k), {31'd0, fi_bus.ready}, 32'd0);
            next_cycle();
        end
        fd_bus.valid = 0;
        #1;
        check("fp_i_ready", {31'd0, fi_bus.ready}, 32'd1);
        check("fp_addr", {19'd0, f_addr}, 32'h005);
        next_cycle();
        idle_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
